mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter BURST_LEN, default 4, words per cache line; power of two, >=2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req_i  in  1  I-cache line-refill request; held until i_done_o.
REQ-007 i_addr_i  in  ADDR_WIDTH  I-cache miss byte address.
REQ-008 i_rdata_o  out  DATA_WIDTH  refill beat data to I-cache.
REQ-009 i_rvalid_o  out  1  i_rdata_o valid this cycle.
REQ-010 i_done_o  out  1  one-cycle pulse, I-cache transaction complete.
REQ-011 d_req_i  in  1  D-cache request; held until d_done_o.
REQ-012 d_we_i  in  1  1 = line writeback, 0 = line refill; stable while d_req_i.
REQ-013 d_addr_i  in  ADDR_WIDTH  D-cache line byte address.
REQ-014 d_wdata_i  in  DATA_WIDTH  writeback word for current beat.
REQ-015 d_wnext_o  out  1  current writeback beat accepted; D-cache advances d_wdata_i.
REQ-016 d_rdata_o  out  DATA_WIDTH  refill beat data to D-cache.
REQ-017 d_rvalid_o  out  1  d_rdata_o valid this cycle.
REQ-018 d_done_o  out  1  one-cycle pulse, D-cache transaction complete.
REQ-019 mem_req_o  out  1  backing-memory beat request.
REQ-020 mem_we_o  out  1  backing-memory write enable.
REQ-021 mem_addr_o  out  ADDR_WIDTH  word-aligned beat address.
REQ-022 mem_wdata_o  out  DATA_WIDTH  beat write data.
REQ-023 mem_ready_i  in  1  memory completes beat this cycle when mem_req_o high.
REQ-024 mem_rdata_i  in  DATA_WIDTH  read data, valid with mem_ready_i.
REQ-025 cpu_stall_o  out  1  pipeline stall; drives the memory-stage enable low.

Function
REQ-026 States IDLE, BURST, DONE; registered grant owner g (I or D), beat counter (log2 BURST_LEN bits), last-grant flag lg, latched base address and write flag.
REQ-027 IDLE: if only one request, grant it; if both, grant the requester != lg; enter BURST next cycle; no request -> stay IDLE.
REQ-028 On grant: base = requester address with low log2(4*BURST_LEN) bits zeroed; write flag = d_we_i for D, 0 for I; beat = 0; lg = granted requester.
REQ-029 BURST: mem_req_o=1, mem_we_o=write flag, mem_addr_o = base + 4*beat, mem_wdata_o = d_wdata_i (combinational passthrough).
REQ-030 Beat completes in a cycle with mem_ready_i=1; beat increments; no progress while mem_ready_i=0, outputs held.
REQ-031 Read beat completion: granted port rvalid=1 and rdata=mem_rdata_i same cycle; other port rvalid=0.
REQ-032 Write beat completion: d_wnext_o=1 same cycle.
REQ-033 Completion of beat BURST_LEN-1 -> DONE; counter wraps to 0; address never crosses the line.
REQ-034 DONE lasts exactly one cycle: granted port's done=1, mem_req_o=0, then IDLE; requests not sampled in DONE.
REQ-035 Requester deasserts req the cycle after its done; a request still high in IDLE is a new transaction.
REQ-036 A request arriving during BURST/DONE waits; no preemption of an active burst.
REQ-037 cpu_stall_o = i_req_i | d_req_i | (state != IDLE), combinational.
REQ-038 Outside BURST: mem_req_o, mem_we_o, all rvalid, d_wnext_o = 0; data/address outputs don't-care but driven.

Reset
REQ-039 rst_n low asynchronously forces IDLE, beat=0, lg=I (D wins first tie), all 1-bit outputs 0, mem_addr_o/mem_wdata_o/rdata outputs 0.
REQ-040 Reset mid-burst abandons the transaction: no done pulse; requesters restart after reset.

Verification
REQ-041 I-only refill, i_addr_i=0x0000_1234, mem_ready_i always 1 -> mem_addr_o 0x1230,0x1234,0x1238,0x123C on 4 consecutive cycles, i_rvalid_o each, i_done_o next cycle, cpu_stall_o high throughout.
REQ-042 Simultaneous i_req_i and d_req_i after reset -> D granted first, I granted in the IDLE cycle after d_done_o; next tie -> I first (lg=D).
REQ-043 D writeback d_addr_i=0x200, mem_ready_i toggling 1,0,1,0... -> 4 d_wnext_o pulses only on ready cycles, mem_we_o=1, d_done_o after 4th accepted beat.
REQ-044 mem_ready_i held 0 for 10 cycles mid-burst -> mem_addr_o, beat frozen, no rvalid, stall held.
REQ-045 rst_n low at beat 2 of refill -> all outputs 0 immediately, no done pulse; after release with request high, new burst starts at beat 0.
REQ-046 Request held high through DONE and deasserted late -> exactly one extra transaction issued from IDLE, none granted during DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter: I-cache refills and D-cache refills/writebacks share
// one word-wide backing memory, one BURST_LEN-beat line transaction at a time.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_rvalid_o,
    output logic                  i_done_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_wnext_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_rvalid_o,
    output logic                  d_done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  cpu_stall_o
);

    localparam int                    BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(4 * BURST_LEN) - ADDR_WIDTH'(1));
    localparam logic                  OWN_I     = 1'b0;
    localparam logic                  OWN_D     = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_lg;
    logic                  r_we;
    logic [BEAT_W-1:0]     r_beat;
    logic [ADDR_WIDTH-1:0] r_base;

    logic                  w_grant_d;
    logic                  w_grant_i;
    logic                  w_burst;
    logic                  w_beat_done;
    logic                  w_read_beat;
    logic [ADDR_WIDTH-1:0] w_off;

    // On a tie the port that did not win last time gets the line.
    assign w_grant_d   = d_req_i & (~i_req_i | (r_lg == OWN_I));
    assign w_grant_i   = i_req_i & ~w_grant_d;
    assign w_burst     = (r_state == S_BURST);
    assign w_beat_done = w_burst & mem_ready_i;
    assign w_read_beat = w_beat_done & ~r_we;
    assign w_off       = {{(ADDR_WIDTH - BEAT_W - 2){1'b0}}, r_beat, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= OWN_I;
            r_lg    <= OWN_I;
            r_we    <= 1'b0;
            r_beat  <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d | w_grant_i) begin
                        r_state <= S_BURST;
                        r_owner <= w_grant_d ? OWN_D : OWN_I;
                        r_lg    <= w_grant_d ? OWN_D : OWN_I;
                        r_we    <= w_grant_d & d_we_i;
                        r_beat  <= '0;
                        r_base  <= (w_grant_d ? d_addr_i : i_addr_i) & LINE_MASK;
                    end
                end
                S_BURST: begin
                    if (mem_ready_i) begin
                        if (r_beat == LAST_BEAT) begin
                            r_beat  <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Beat-level handshakes are same-cycle with mem_ready_i; everything else decodes state.
    assign mem_req_o   = w_burst;
    assign mem_we_o    = w_burst & r_we;
    assign mem_addr_o  = w_burst ? (r_base | w_off) : '0;
    assign mem_wdata_o = w_burst ? d_wdata_i : '0;

    assign i_rvalid_o  = w_read_beat & (r_owner == OWN_I);
    assign d_rvalid_o  = w_read_beat & (r_owner == OWN_D);
    assign i_rdata_o   = i_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    assign d_wnext_o   = w_beat_done & r_we;

    assign i_done_o    = (r_state == S_DONE) & (r_owner == OWN_I);
    assign d_done_o    = (r_state == S_DONE) & (r_owner == OWN_D);

    assign cpu_stall_o = rst_n & (i_req_i | d_req_i | (r_state != S_IDLE));

endmodule
